// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit:
// opcodes, ALU op codes, immediate-extension codes, FSM states and decode record.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_LUI  = 2'b10;
  localparam logic [1:0] IMM_BR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IFETCH = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE   = 3'd0,
    CL_ALUIMM  = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_ILLEGAL = 3'd5
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   alu_func;
    logic [1:0]   imm_ext;
    logic         byte_op;
    logic         rf_b_sel;
    logic         alu_bin_sel;
    logic         is_b;
    logic         is_beq;
    logic         is_bne;
  } dec_t;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_sel;
    logic [3:0] alu_func;
    logic       alu_bin_sel;
    logic [1:0] imm_ext;
    logic       rf_b_sel;
    logic       rf_wr;
    logic       rf_wd_sel;
    logic       mem_wr;
    logic       byte_op;
    logic       illegal;
  } ctrl_out_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/func decoder: instruction class plus the per-opcode
// ALU op, immediate extension, operand selects and branch flavour.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [3:0] func_i,
  output dec_t       dec_o
);

  // Opcode table; anything not listed is classed illegal with all selects at 0
  always_comb begin
    dec_o     = '0;
    dec_o.cls = CL_ILLEGAL;
    case (opcode_i)
      OP_RTYPE: begin
        dec_o.cls      = CL_RTYPE;
        dec_o.alu_func = func_i;
      end
      OP_ADDI, OP_LI, OP_LUI, OP_ANDI, OP_ORI: begin
        dec_o.cls         = CL_ALUIMM;
        dec_o.rf_b_sel    = 1'b1;
        dec_o.alu_bin_sel = 1'b1;
        case (opcode_i)
          OP_LUI:  begin dec_o.alu_func = ALU_ADD; dec_o.imm_ext = IMM_LUI;  end
          OP_ANDI: begin dec_o.alu_func = ALU_AND; dec_o.imm_ext = IMM_ZEXT; end
          OP_ORI:  begin dec_o.alu_func = ALU_OR;  dec_o.imm_ext = IMM_ZEXT; end
          default: begin dec_o.alu_func = ALU_ADD; dec_o.imm_ext = IMM_SEXT; end
        endcase
      end
      OP_LB, OP_LW, OP_SB, OP_SW: begin
        dec_o.cls         = ((opcode_i == OP_LB) || (opcode_i == OP_LW)) ? CL_LOAD : CL_STORE;
        dec_o.alu_func    = ALU_ADD;
        dec_o.imm_ext     = IMM_SEXT;
        dec_o.rf_b_sel    = 1'b1;
        dec_o.alu_bin_sel = 1'b1;
        dec_o.byte_op     = (opcode_i == OP_LB) || (opcode_i == OP_SB);
      end
      OP_BEQ, OP_BNE, OP_B: begin
        dec_o.cls      = CL_BRANCH;
        dec_o.alu_func = ALU_SUB;
        dec_o.imm_ext  = IMM_BR;
        dec_o.rf_b_sel = 1'b1;
        dec_o.is_beq   = (opcode_i == OP_BEQ);
        dec_o.is_bne   = (opcode_i == OP_BNE);
        dec_o.is_b     = (opcode_i == OP_B);
      end
      default: begin
        dec_o.cls = CL_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM (IFETCH/DECODE/EXEC/MEM/WB) for the MIPS-subset datapath.
// Define CTRL_TRAP_EN to trap unknown opcodes in a sticky TRAP state; otherwise they run as NOPs.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic [3:0]  ALU_func,
  output logic        ALU_Bin_sel,
  output logic [1:0]  ImmExt,
  output logic        RF_B_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        Mem_WrEn,
  output logic        ByteOp,
  output logic        Illegal
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  dec_t       dec_s;
  ctrl_out_t  out_s, gated_s;
  logic       taken_s;
  logic       mem_last_s;
  logic       unused_instr_s;

  instr_decoder u_dec (
    .opcode_i (Instr[31:26]),
    .func_i   (Instr[3:0]),
    .dec_o    (dec_s)
  );

  assign unused_instr_s = ^Instr[25:4];
  assign taken_s        = dec_s.is_b | (dec_s.is_beq & Zero) | (dec_s.is_bne & ~Zero);
  assign mem_last_s     = (cnt_q == MEM_LAST);

  // State and MEM wait-counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IFETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore outputs; only the EXEC branch decision looks at Zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_s   = '0;
    case (state_q)
      ST_IFETCH: begin
        out_s.ir_ld = 1'b1;
        state_d     = ST_DECODE;
      end
      ST_DECODE: begin
        out_s.rf_b_sel = dec_s.rf_b_sel;
        out_s.imm_ext  = dec_s.imm_ext;
`ifdef CTRL_TRAP_EN
        if (dec_s.cls == CL_ILLEGAL) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
`else
        state_d = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        out_s.rf_b_sel    = dec_s.rf_b_sel;
        out_s.imm_ext     = dec_s.imm_ext;
        out_s.alu_func    = dec_s.alu_func;
        out_s.alu_bin_sel = dec_s.alu_bin_sel;
        case (dec_s.cls)
          CL_BRANCH: begin
            out_s.pc_ld  = 1'b1;
            out_s.pc_sel = taken_s;
            state_d      = ST_IFETCH;
          end
          CL_LOAD, CL_STORE: begin
            state_d = ST_MEM;
          end
          CL_RTYPE, CL_ALUIMM: begin
            state_d = ST_WB;
          end
          default: begin
            // Unknown opcode retires as a NOP: just advance the PC
            out_s.pc_ld = 1'b1;
            state_d     = ST_IFETCH;
          end
        endcase
      end
      ST_MEM: begin
        out_s.rf_b_sel = dec_s.rf_b_sel;
        out_s.imm_ext  = dec_s.imm_ext;
        out_s.byte_op  = dec_s.byte_op;
        if (mem_last_s) begin
          cnt_d = 4'd0;
          if (dec_s.cls == CL_STORE) begin
            out_s.mem_wr = 1'b1;
            out_s.pc_ld  = 1'b1;
            state_d      = ST_IFETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WB: begin
        out_s.rf_b_sel  = dec_s.rf_b_sel;
        out_s.imm_ext   = dec_s.imm_ext;
        out_s.rf_wr     = 1'b1;
        out_s.rf_wd_sel = (dec_s.cls == CL_LOAD);
        out_s.pc_ld     = 1'b1;
        state_d         = ST_IFETCH;
      end
      ST_TRAP: begin
`ifdef CTRL_TRAP_EN
        out_s.illegal = 1'b1;
        state_d       = ST_TRAP;
`else
        state_d = ST_IFETCH;
`endif
      end
      default: begin
        state_d = ST_IFETCH;
      end
    endcase
  end

  assign gated_s       = Reset ? '0 : out_s;

  assign IR_LdEn       = gated_s.ir_ld;
  assign PC_LdEn       = gated_s.pc_ld;
  assign PC_sel        = gated_s.pc_sel;
  assign ALU_func      = gated_s.alu_func;
  assign ALU_Bin_sel   = gated_s.alu_bin_sel;
  assign ImmExt        = gated_s.imm_ext;
  assign RF_B_sel      = gated_s.rf_b_sel;
  assign RF_WrEn       = gated_s.rf_wr;
  assign RF_WrData_sel = gated_s.rf_wd_sel;
  assign Mem_WrEn      = gated_s.mem_wr;
  assign ByteOp        = gated_s.byte_op;
  assign Illegal       = gated_s.illegal;

endmodule

// File: tb/tb_control_fsm.sv
// Randomised self-checking bench for control_fsm: two instances (MEM_LAT 0 and 2)
// checked every cycle against a cycle-index reference model, plus pinned directed cases.
module tb_control_fsm;

  localparam int LAT0 = 0;
  localparam int LAT1 = 2;
  localparam int NCYC = 4000;
`ifdef CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam int C_R = 0, C_AI = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_IL = 5;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] instr_s [2];
  logic        zero_s  [2];

  logic [3:0] alu0, alu1;
  logic [1:0] imm0, imm1;
  logic ir0, pc0, ps0, bin0, rfb0, rfw0, rfd0, mw0, bo0, il0;
  logic ir1, pc1, ps1, bin1, rfb1, rfw1, rfd1, mw1, bo1, il1;
  logic [15:0] out0, out1;

  int n_checks = 0;
  int n_err    = 0;

  int          k       [2];
  bit          trapped [2];
  logic [31:0] cur     [2];
  logic [1:0]  zmode   [2];
  logic [33:0] dq0 [$];
  logic [33:0] dq1 [$];
  logic [15:0] hist0 [0:63];
  logic [15:0] hist1 [0:63];

  always #5 Clk = ~Clk;

  control_fsm #(.MEM_LAT(LAT0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Instr(instr_s[0]), .Zero(zero_s[0]),
    .IR_LdEn(ir0), .PC_LdEn(pc0), .PC_sel(ps0), .ALU_func(alu0), .ALU_Bin_sel(bin0),
    .ImmExt(imm0), .RF_B_sel(rfb0), .RF_WrEn(rfw0), .RF_WrData_sel(rfd0),
    .Mem_WrEn(mw0), .ByteOp(bo0), .Illegal(il0)
  );

  control_fsm #(.MEM_LAT(LAT1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Instr(instr_s[1]), .Zero(zero_s[1]),
    .IR_LdEn(ir1), .PC_LdEn(pc1), .PC_sel(ps1), .ALU_func(alu1), .ALU_Bin_sel(bin1),
    .ImmExt(imm1), .RF_B_sel(rfb1), .RF_WrEn(rfw1), .RF_WrData_sel(rfd1),
    .Mem_WrEn(mw1), .ByteOp(bo1), .Illegal(il1)
  );

  // Output vector layout: IR PC PCsel ALU[4] Bin Imm[2] RFB RFWr RFWD MemWr Byte Illegal
  assign out0 = {ir0, pc0, ps0, alu0, bin0, imm0, rfb0, rfw0, rfd0, mw0, bo0, il0};
  assign out1 = {ir1, pc1, ps1, alu1, bin1, imm1, rfb1, rfw1, rfd1, mw1, bo1, il1};

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100000:                                  return C_R;
      6'b110000, 6'b111000, 6'b111001,
      6'b110010, 6'b110011:                       return C_AI;
      6'b000011, 6'b001111:                       return C_LD;
      6'b000111, 6'b011111:                       return C_ST;
      6'b000000, 6'b000001, 6'b111111:            return C_BR;
      default:                                    return C_IL;
    endcase
  endfunction

  function automatic int ilen(input int lat, input int cls);
    case (cls)
      C_R, C_AI: return 4;
      C_LD:      return 5 + lat;
      C_ST:      return 4 + lat;
      default:   return 3;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [5:0] op);
    case (op)
      6'b111001:             return 2'b10;
      6'b110010, 6'b110011:  return 2'b01;
      6'b000000, 6'b000001,
      6'b111111:             return 2'b11;
      default:               return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] ins);
    case (ins[31:26])
      6'b100000:                        return ins[3:0];
      6'b110010:                        return 4'b0010;
      6'b110011:                        return 4'b0011;
      6'b000000, 6'b000001, 6'b111111:  return 4'b0001;
      default:                          return 4'b0000;
    endcase
  endfunction

  // Expected outputs from the position k (cycles since fetch) inside the current instruction
  function automatic logic [15:0] model_out(input int lat, input int kk, input bit trp,
                                            input logic [31:0] ins, input logic z, input logic rst);
    logic [15:0] o;
    logic [5:0]  op;
    int          cls;
    o   = 16'h0000;
    op  = ins[31:26];
    cls = classify(op);
    if (rst) return 16'h0000;
    if (trp) begin
      o[0] = 1'b1;
      return o;
    end
    if (kk == 0) o[15] = 1'b1;
    if (kk >= 1 && cls != C_IL) begin
      o[5]   = (cls != C_R);
      o[7:6] = imm_of(op);
    end
    if (kk == 2) begin
      o[12:9] = alu_of(ins);
      o[8]    = (cls == C_AI) || (cls == C_LD) || (cls == C_ST);
      if (cls == C_BR) begin
        o[14] = 1'b1;
        o[13] = (op == 6'b111111) || (op == 6'b000000 && z) || (op == 6'b000001 && !z);
      end
      if (cls == C_IL) o[14] = 1'b1;
    end
    if ((cls == C_LD || cls == C_ST) && kk >= 3 && kk <= 3 + lat) begin
      o[1] = (op == 6'b000011) || (op == 6'b000111);
      if (kk == 3 + lat && cls == C_ST) begin
        o[2]  = 1'b1;
        o[14] = 1'b1;
      end
    end
    if ((cls == C_R || cls == C_AI || cls == C_LD) && kk == ilen(lat, cls) - 1) begin
      o[4]  = 1'b1;
      o[3]  = (cls == C_LD);
      o[14] = 1'b1;
    end
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 13))
      0:  op = 6'b100000;  1: op = 6'b110000;  2: op = 6'b111000;  3: op = 6'b111001;
      4:  op = 6'b110010;  5: op = 6'b110011;  6: op = 6'b000011;  7: op = 6'b001111;
      8:  op = 6'b000111;  9: op = 6'b011111; 10: op = 6'b000000; 11: op = 6'b000001;
      12: op = 6'b111111;
      default: op = 6'($urandom);
    endcase
    return {op, 26'($urandom)};
  endfunction

  task automatic check(input string name, input int lane, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s lane%0d: got %h expected %h", name, lane, act, exp_v);
    end
  endtask

  initial begin
    logic [33:0] e;
    logic [15:0] act;
    int          cls;
    Reset      = 1'b1;
    instr_s[0] = 32'h0000_0000;
    instr_s[1] = 32'h0000_0000;
    zero_s[0]  = 1'b0;
    zero_s[1]  = 1'b0;
    for (int l = 0; l < 2; l++) begin
      k[l] = 0; trapped[l] = 1'b0; cur[l] = 32'h0000_0000; zmode[l] = 2'd2;
    end
    // Lane 0 (MEM_LAT=0): add R-type, beq taken, beq not taken, sb, unknown opcode
    dq0.push_back({2'd2, 6'b100000, 20'h12345, 6'b110000});
    dq0.push_back({2'd1, 6'b000000, 26'h0000010});
    dq0.push_back({2'd0, 6'b000000, 26'h0000010});
    dq0.push_back({2'd2, 6'b000111, 26'h0A50004});
    dq0.push_back({2'd2, 6'b010101, 26'h0000000});
    // Lane 1 (MEM_LAT=2): lw, add, ori, ori (reset lands in its EXEC)
    dq1.push_back({2'd2, 6'b001111, 26'h0210008});
    dq1.push_back({2'd2, 6'b100000, 20'h00abc, 6'b110000});
    dq1.push_back({2'd2, 6'b110011, 26'h00300FF});
    dq1.push_back({2'd2, 6'b110011, 26'h01400F0});

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge Clk);
      #1;
      Reset = (cyc < 2) || (cyc == 19) || (cyc > 40 && $urandom_range(0, 29) == 0);
      for (int l = 0; l < 2; l++) begin
        if (k[l] == 0 && !trapped[l] && !Reset) begin
          if (l == 0 && dq0.size() > 0)      e = dq0.pop_front();
          else if (l == 1 && dq1.size() > 0) e = dq1.pop_front();
          else                               e = {2'd2, rand_instr()};
          cur[l]     = e[31:0];
          zmode[l]   = e[33:32];
          instr_s[l] = cur[l];
        end
        zero_s[l] = (zmode[l] == 2'd2) ? 1'($urandom) : zmode[l][0];
      end
      #2;
      for (int l = 0; l < 2; l++) begin
        act = (l == 0) ? out0 : out1;
        check("cycle_outputs", l,
              act, model_out((l == 0) ? LAT0 : LAT1, k[l], trapped[l], cur[l], zero_s[l], Reset));
        if (cyc < 64) begin
          if (l == 0) hist0[cyc] = act;
          else        hist1[cyc] = act;
        end
        if (Reset) begin
          k[l] = 0;
          trapped[l] = 1'b0;
        end else if (!trapped[l]) begin
          cls = classify(cur[l][31:26]);
          if (TRAP_EN && cls == C_IL && k[l] == 1) begin
            trapped[l] = 1'b1;
          end else begin
            k[l] = k[l] + 1;
            if (k[l] == ilen((l == 0) ? LAT0 : LAT1, cls)) k[l] = 0;
          end
        end
      end
    end

    // Hand-derived expectations for the directed prologue
    check("add_exec_alu_bin",   0, {11'd0, hist0[4][12:8]}, 16'h0000);
    check("add_wb_wr_pc",       0, {13'd0, hist0[5][4], hist0[5][14], hist0[5][13]}, 16'h0006);
    check("add_len4_refetch",   0, {15'd0, hist0[6][15]}, 16'h0001);
    check("beq_taken_exec",     0, {10'd0, hist0[8][12:9], hist0[8][14], hist0[8][13]}, 16'h0007);
    check("beq_nottaken_exec",  0, {14'd0, hist0[11][14], hist0[11][13]}, 16'h0002);
    check("sb_mem_pulse",       0, {12'd0, hist0[15][2], hist0[15][1], hist0[15][14], hist0[15][4]}, 16'h000E);
    check("sb_refetch",         0, {15'd0, hist0[16][15]}, 16'h0001);
`ifdef CTRL_TRAP_EN
    check("illegal_trap",       0, {13'd0, hist0[18][14], hist0[18][13], hist0[18][0]}, 16'h0001);
`else
    check("illegal_nop_exec",   0, {13'd0, hist0[18][14], hist0[18][13], hist0[18][0]}, 16'h0004);
`endif
    check("lw_exec_alu_bin",    1, {11'd0, hist1[4][12:8]}, 16'h0001);
    check("lw_mem_last_no_wr",  1, {14'd0, hist1[7][4], hist1[7][14]}, 16'h0000);
    check("lw_wb",              1, {13'd0, hist1[8][4], hist1[8][3], hist1[8][14]}, 16'h0007);
    check("lw_refetch",         1, {15'd0, hist1[9][15]}, 16'h0001);
    check("ori_fetch",          1, {15'd0, hist1[17][15]}, 16'h0001);
    check("reset_in_exec",      1, hist1[19], 16'h0000);
    check("fetch_after_reset",  1, {15'd0, hist1[20][15]}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
